// File: rtl/secded_decoder_pipe_if.sv
// Valid/ready stream bundle for the SECDED decoder: received beat in, decoded beat out.
interface secded_decoder_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CHK_W  = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [CHK_W-1:0]  s_check;
  logic              s_chk_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CHK_W-1:0]  m_syndrome;
  logic              m_corr;
  logic              m_uncorr;

  modport master (
    output s_valid, s_data, s_check, s_chk_en, m_ready,
    input  s_ready, m_valid, m_data, m_syndrome, m_corr, m_uncorr
  );

  modport slave (
    input  s_valid, s_data, s_check, s_chk_en, m_ready,
    output s_ready, m_valid, m_data, m_syndrome, m_corr, m_uncorr
  );
endinterface

// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined SECDED (Hsiao-style) decoder with valid/ready flow control.
// Define SECDED_ERR_CNT_EN to build the corrected/uncorrectable beat counters.
module secded_decoder_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CHK_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  secded_decoder_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);

  function automatic bit is_col_code(input logic [CHK_W-1:0] c);
    return ($countones(c) >= 3) && (($countones(c) % 2) == 1);
  endfunction

  function automatic int unsigned num_cols();
    int unsigned n;
    n = 0;
    for (int unsigned v = 0; v < (32'd1 << CHK_W); v++) begin
      if (is_col_code(CHK_W'(v))) n++;
    end
    return n;
  endfunction

  // Data column idx is the idx-th odd-weight (>=3) code in ascending order.
  function automatic logic [CHK_W-1:0] h_col(input int unsigned idx);
    int unsigned      n;
    logic [CHK_W-1:0] r;
    n = 0;
    r = '0;
    for (int unsigned v = 0; v < (32'd1 << CHK_W); v++) begin
      if (is_col_code(CHK_W'(v))) begin
        if (n == idx) r = CHK_W'(v);
        n++;
      end
    end
    return r;
  endfunction

  if (DATA_W > num_cols()) begin : g_param_err
    $error("DATA_W exceeds the number of odd-weight check columns for CHK_W");
  end

  logic [CHK_W-1:0] cols [DATA_W];
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_col
    assign cols[gi] = h_col(gi);
  end

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [CHK_W-1:0]  s1_syn_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic [CHK_W-1:0]  m_syn_q;
  logic              m_corr_q;
  logic              m_uncorr_q;

  logic [CHK_W-1:0]  syn_d;
  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_uncorr;
  logic              dec_hit;
  logic              s1_adv;
  logic              s_ready;

  assign s1_adv  = s1_valid_q && (!m_valid_q || bus.m_ready);
  assign s_ready = !s1_valid_q || s1_adv;

  always_comb begin
    syn_d = bus.s_check & {CHK_W{bus.s_chk_en}};
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (bus.s_data[i]) syn_d = syn_d ^ cols[i];
    end
  end

  always_comb begin
    dec_data   = s1_data_q;
    dec_hit    = 1'b0;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (s1_syn_q == cols[i]) begin
        dec_data[i] = ~s1_data_q[i];
        dec_hit     = 1'b1;
      end
    end
    // One-hot syndrome is a check-bit error: data passes through untouched.
    if (s1_syn_q != '0) begin
      if (dec_hit || $onehot(s1_syn_q)) dec_corr = 1'b1;
      else                              dec_uncorr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
    end else begin
      if (s_ready) s1_valid_q <= bus.s_valid;
      if (bus.s_valid && s_ready) begin
        s1_data_q <= bus.s_data;
        s1_syn_q  <= syn_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_syn_q    <= '0;
      m_corr_q   <= 1'b0;
      m_uncorr_q <= 1'b0;
    end else begin
      if (!m_valid_q || bus.m_ready) m_valid_q <= s1_valid_q;
      if (s1_adv) begin
        m_data_q   <= dec_data;
        m_syn_q    <= s1_syn_q;
        m_corr_q   <= dec_corr;
        m_uncorr_q <= dec_uncorr;
      end
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_syndrome = m_syn_q;
  assign bus.m_corr     = m_corr_q;
  assign bus.m_uncorr   = m_uncorr_q;

`ifdef SECDED_ERR_CNT_EN
  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_q;
  logic             out_hs;

  assign out_hs = m_valid_q && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      if (out_hs && m_corr_q && (corr_cnt_q != '1))     corr_cnt_q   <= corr_cnt_q + 1'b1;
      if (out_hs && m_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Bench for secded_decoder_pipe: directed vector table, stall/reset/counter sequences and
// a randomized stream scored against a brute-force decode model.
module tb_secded_decoder_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 2;
`ifdef SECDED_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] syn;
    logic          corr;
    logic          uncorr;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] check;
    logic          en;
    exp_t          exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [NW-1:0] corr_cnt;
  logic [NW-1:0] uncorr_cnt;
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] col_tab [DW];
  exp_t          q[$];
  int            mc = 0;
  int            mu = 0;
  bit            prev_hold = 1'b0;
  exp_t          prev;
  bit            done = 1'b0;
  vec_t          vecs [12];

  secded_decoder_pipe_if #(.DATA_W(DW), .CHK_W(CW)) bus ();

  secded_decoder_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(NW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t dut_out();
    return {bus.m_data, bus.m_syndrome, bus.m_corr, bus.m_uncorr};
  endfunction

  function automatic logic [CW-1:0] ref_syn(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                            input logic en);
    logic [CW-1:0] s;
    s = en ? c : '0;
    for (int i = 0; i < int'(DW); i++) if (d[i]) s = s ^ col_tab[i];
    return s;
  endfunction

  function automatic logic [CW-1:0] ref_enc(input logic [DW-1:0] d);
    return ref_syn(d, '0, 1'b1);
  endfunction

  // Correction found by searching for the single data-bit flip that yields a zero syndrome.
  function automatic exp_t ref_decode(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                      input logic en);
    exp_t e;
    e.syn    = ref_syn(d, c, en);
    e.data   = d;
    e.corr   = 1'b0;
    e.uncorr = 1'b0;
    if (e.syn != '0) begin
      if ($countones(e.syn) == 1) e.corr = 1'b1;
      else begin
        for (int i = 0; i < int'(DW); i++) begin
          if (ref_syn(d ^ (32'd1 << i), c, en) == '0) begin
            e.data = d ^ (32'd1 << i);
            e.corr = 1'b1;
          end
        end
        if (!e.corr) e.uncorr = 1'b1;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      mc = 0;
      mu = 0;
      prev_hold = 1'b0;
    end else begin
      chk("corr_cnt", 64'(corr_cnt), 64'(mc));
      chk("uncorr_cnt", 64'(uncorr_cnt), 64'(mu));
      if (prev_hold) chk("stall_hold", {bus.m_valid, dut_out()}, {1'b1, prev});
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_beat actual=%h required=none", dut_out());
        end else begin
          e = q.pop_front();
          chk("out_beat", dut_out(), e);
          if (CntEn) begin
            if (e.corr && mc < 3) mc++;
            if (e.uncorr && mu < 3) mu++;
          end
        end
      end
      if (cnt_clr) begin
        mc = 0;
        mu = 0;
      end
      if (bus.s_valid && bus.s_ready) q.push_back(ref_decode(bus.s_data, bus.s_check, bus.s_chk_en));
      chk("occupancy_le2", 64'(q.size() <= 2), 64'd1);
      prev_hold = bus.m_valid && !bus.m_ready;
      prev = dut_out();
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic en);
    int n = 0;
    bus.s_valid  = 1'b1;
    bus.s_data   = d;
    bus.s_check  = c;
    bus.s_chk_en = en;
    @(negedge clk);
    while (!bus.s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      checks++;
      failures++;
      $display("FAIL s_ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.m_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [CW-1:0] enc;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          en;
    bit            saw_low;
    int            n;

    for (int i = 0; i < int'(DW); i++) begin
      n = 0;
      for (int v = 0; v < 256; v++) begin
        c = 8'(v);
        if ($countones(c) >= 3 && ($countones(c) % 2) == 1) begin
          if (n == i) col_tab[i] = c;
          n++;
        end
      end
    end
    enc = ref_enc(32'hDEADBEEF);

    vecs[0]  = '{32'hDEADBEEF, enc,         1'b1, '{32'hDEADBEEF, 8'h00, 1'b0, 1'b0}};
    vecs[1]  = '{32'hDEADBECF, enc,         1'b1, '{32'hDEADBEEF, 8'h15, 1'b1, 1'b0}};
    vecs[2]  = '{32'hDEADBEEF, enc ^ 8'h08, 1'b1, '{32'hDEADBEEF, 8'h08, 1'b1, 1'b0}};
    vecs[3]  = '{32'hDEADBEEC, enc,         1'b1, '{32'hDEADBEEC, 8'h0C, 1'b0, 1'b1}};
    vecs[4]  = '{32'h00000000, 8'h08,       1'b0, '{32'h00000000, 8'h00, 1'b0, 1'b0}};
    vecs[5]  = '{32'h00000001, 8'h00,       1'b0, '{32'h00000000, 8'h07, 1'b1, 1'b0}};
    vecs[6]  = '{32'h00000003, 8'h0C,       1'b1, '{32'h00000003, 8'h00, 1'b0, 1'b0}};
    vecs[7]  = '{32'h00000000, 8'h03,       1'b1, '{32'h00000000, 8'h03, 1'b0, 1'b1}};
    vecs[8]  = '{32'h00000000, 8'h7F,       1'b1, '{32'h00000000, 8'h7F, 1'b0, 1'b1}};
    vecs[9]  = '{32'h00000000, 8'h07,       1'b1, '{32'h00000001, 8'h07, 1'b1, 1'b0}};
    vecs[10] = '{32'h80000000, 8'h00,       1'b1, '{32'h00000000, 8'h4C, 1'b1, 1'b0}};
    vecs[11] = '{32'h00000000, 8'hFF,       1'b1, '{32'h00000000, 8'hFF, 1'b0, 1'b1}};

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_check  = '0;
    bus.s_chk_en = 1'b0;
    bus.m_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_m_out", dut_out(), 64'd0);
    chk("rst_cnts", 64'({corr_cnt, uncorr_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: one beat at a time, with exact N+2 latency.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].data, vecs[i].check, vecs[i].en);
      @(negedge clk);
      chk("lat_n1_valid", 64'(bus.m_valid), 64'd0);
      @(negedge clk);
      chk("lat_n2_valid", 64'(bus.m_valid), 64'd1);
      chk($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
      if (i == 3) begin
        @(negedge clk);
        chk("uncorr_cnt_inc", 64'(uncorr_cnt), CntEn ? 64'd1 : 64'd0);
      end
      @(posedge clk);
      #1;
    end

    // Four-beat stream with downstream stalled for five cycles.
    saw_low = 1'b0;
    fork
      for (int k = 0; k < 4; k++) begin
        d = $urandom();
        send(d, ref_enc(d), 1'b1);
      end
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        if (k == 1) bus.m_ready = 1'b0;
        if (k == 6) bus.m_ready = 1'b1;
      end
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (!bus.s_ready) saw_low = 1'b1;
      end
    join
    chk("sready_drop", 64'(saw_low), 64'd1);
    drain();

    // Counter saturation and clear-over-increment priority.
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) send(32'h12345678 ^ (32'd1 << k), ref_enc(32'h12345678), 1'b1);
    drain();
    chk("corr_cnt_sat", 64'(corr_cnt), CntEn ? 64'd3 : 64'd0);
    @(posedge clk);
    #1 bus.m_ready = 1'b0;
    send(32'h0F0F0F0F ^ 32'h100, ref_enc(32'h0F0F0F0F), 1'b1);
    n = 0;
    while (!bus.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clr_setup_valid", 64'(bus.m_valid), 64'd1);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("corr_cnt_clr_prio", 64'(corr_cnt), 64'd0);
    @(posedge clk);
    #1;

    // Randomized stream with random backpressure and occasional clears.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          d   = $urandom();
          c   = ref_enc(d);
          en  = 1'b1;
          case ($urandom_range(0, 4))
            1: d = d ^ (32'd1 << $urandom_range(0, 31));
            2: c = c ^ (8'd1 << $urandom_range(0, 7));
            3: d = d ^ (32'd1 << $urandom_range(0, 15)) ^ (32'd1 << $urandom_range(16, 31));
            4: begin
              c  = 8'($urandom());
              en = 1'($urandom_range(0, 1));
            end
            default: ;
          endcase
          send(d, c, en);
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        bus.m_ready = ($urandom_range(0, 3) != 0);
        cnt_clr     = ($urandom_range(0, 19) == 0);
      end
    join
    bus.m_ready = 1'b1;
    cnt_clr = 1'b0;
    drain();

    // Reset while two beats are buffered.
    @(posedge clk);
    #1 bus.m_ready = 1'b0;
    send(32'hCAFEF00D ^ 32'h4, ref_enc(32'hCAFEF00D), 1'b1);
    send(32'h0BADC0DE ^ 32'h3, ref_enc(32'h0BADC0DE), 1'b1);
    @(negedge clk);
    chk("pre_rst_valid", 64'(bus.m_valid), 64'd1);
    chk("pre_rst_sready", 64'(bus.s_ready), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("midrst_m_out", dut_out(), 64'd0);
    chk("midrst_cnts", 64'({corr_cnt, uncorr_cnt}), 64'd0);
    chk("midrst_s_ready", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    d = 32'h55AA55AA;
    send(d, ref_enc(d), 1'b1);
    @(negedge clk);
    chk("post_rst_n1_valid", 64'(bus.m_valid), 64'd0);
    @(negedge clk);
    chk("post_rst_n2_valid", 64'(bus.m_valid), 64'd1);
    chk("post_rst_beat", dut_out(), {d, 8'h00, 1'b0, 1'b0});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
